// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of one shared W-bit ALU with a fixed result latency.
// Operands are registered onto the ALU; after LAT edges the results are captured and a done pulse is returned.
module alu_arbiter #(
    parameter int LAT = 1,
    parameter int W   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    input  logic [7:0]   op0,
    input  logic [7:0]   op1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic [1:0]   cin,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic         busy,
    output logic [W-1:0] res,
    output logic [W-1:0] res_c,
    output logic         res_cf,
    output logic         res_zf,
    output logic         res_of,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [7:0]   alu_op,
    output logic         alu_cf,
    input  logic [W-1:0] alu_acc,
    input  logic [W-1:0] alu_c,
    input  logic         alu_cflag,
    input  logic         alu_zflag,
    input  logic         alu_oflag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_t     state_r;
    logic [3:0] cnt_r;
    logic       last_r;
    logic       grant_s;
    logic       win_s;

    // Winner selection: a lone requester wins outright, a tie goes to the port not served last.
    always_comb begin
        grant_s = 1'b0;
        win_s   = 1'b0;
        case (req)
            2'b01: begin
                grant_s = 1'b1;
                win_s   = 1'b0;
            end
            2'b10: begin
                grant_s = 1'b1;
                win_s   = 1'b1;
            end
            2'b11: begin
                grant_s = 1'b1;
                win_s   = ~last_r;
            end
            default: begin
                grant_s = 1'b0;
                win_s   = 1'b0;
            end
        endcase
    end

    // Arbitration FSM: registered ALU drive, latency count, result capture and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            last_r  <= 1'b1;
            gnt     <= 2'b00;
            done    <= 2'b00;
            busy    <= 1'b0;
            res     <= '0;
            res_c   <= '0;
            res_cf  <= 1'b0;
            res_zf  <= 1'b0;
            res_of  <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= 8'h00;
            alu_cf  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        gnt     <= win_s ? 2'b10 : 2'b01;
                        alu_a   <= win_s ? a1 : a0;
                        alu_b   <= win_s ? b1 : b0;
                        alu_op  <= win_s ? op1 : op0;
                        alu_cf  <= cin[win_s];
                        last_r  <= win_s;
                        cnt_r   <= LAT_C;
                        busy    <= 1'b1;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        res     <= alu_acc;
                        res_c   <= alu_c;
                        res_cf  <= alu_cflag;
                        res_zf  <= alu_zflag;
                        res_of  <= alu_oflag;
                        done    <= gnt;
                        state_r <= ST_DONE;
                    end
                end
                // Dead cycle so the served requester can drop req before the next arbitration.
                ST_DONE: begin
                    done    <= 2'b00;
                    gnt     <= 2'b00;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 2'b00;
                    gnt     <= 2'b00;
                    busy    <= 1'b0;
                    cnt_r   <= 4'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (LAT=1 and LAT=3), each with a latency-aware ALU stand-in,
// a transaction-level reference model checked every cycle, and directed vectors with literal expectations.
module tb_alu_arbiter;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         rst_n [2];
    logic [1:0]   req   [2];
    logic [7:0]   op0   [2];
    logic [7:0]   op1   [2];
    logic [W-1:0] a0    [2];
    logic [W-1:0] b0    [2];
    logic [W-1:0] a1    [2];
    logic [W-1:0] b1    [2];
    logic [1:0]   cin   [2];

    logic [1:0]   gnt    [2];
    logic [1:0]   done   [2];
    logic         busy   [2];
    logic [W-1:0] res    [2];
    logic [W-1:0] res_c  [2];
    logic         res_cf [2];
    logic         res_zf [2];
    logic         res_of [2];
    logic [W-1:0] alu_a  [2];
    logic [W-1:0] alu_b  [2];
    logic [7:0]   alu_op [2];
    logic         alu_cf [2];

    // Reference ALU: {acc, c, cflag, zflag, oflag}.
    function automatic logic [34:0] alu_f(input logic [7:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cf);
        logic [16:0] s;
        logic [15:0] acc;
        logic        c;
        logic        o;
        case (op)
            8'h01: begin
                s   = {1'b0, a} + {1'b0, b} + {16'd0, cf};
                acc = s[15:0];
                c   = s[16];
                o   = (a[15] == b[15]) && (acc[15] != a[15]);
            end
            8'h03: begin
                s   = {1'b0, a} - {1'b0, b} - {16'd0, cf};
                acc = s[15:0];
                c   = s[16];
                o   = (a[15] != b[15]) && (acc[15] != a[15]);
            end
            default: begin
                acc = a & b;
                c   = 1'b0;
                o   = 1'b0;
            end
        endcase
        return {acc, a ^ b, c, acc == 16'd0, o};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int L = (g == 0) ? 1 : 3;

        logic [W-1:0] alu_acc;
        logic [W-1:0] alu_c;
        logic         alu_cflag;
        logic         alu_zflag;
        logic         alu_oflag;
        logic         rn;
        logic [34:0]  fr;
        logic [40:0]  prev = '0;
        int           age = 0;

        alu_arbiter #(.LAT(L), .W(W)) u_dut (
            .clk(clk), .rst_n(rst_n[g]), .req(req[g]),
            .op0(op0[g]), .op1(op1[g]), .a0(a0[g]), .b0(b0[g]), .a1(a1[g]), .b1(b1[g]),
            .cin(cin[g]), .gnt(gnt[g]), .done(done[g]), .busy(busy[g]),
            .res(res[g]), .res_c(res_c[g]), .res_cf(res_cf[g]), .res_zf(res_zf[g]),
            .res_of(res_of[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_op(alu_op[g]),
            .alu_cf(alu_cf[g]), .alu_acc(alu_acc), .alu_c(alu_c), .alu_cflag(alu_cflag),
            .alu_zflag(alu_zflag), .alu_oflag(alu_oflag)
        );

        // ALU stand-in: outputs are garbage until the inputs have been stable for LAT cycles.
        assign rn = rst_n[g];
        assign fr = alu_f(alu_op[g], alu_a[g], alu_b[g], alu_cf[g]);
        assign {alu_acc, alu_c, alu_cflag, alu_zflag, alu_oflag} = (age >= L - 1) ? fr : ~fr;

        always @(posedge clk) begin
            #1;
            if ({alu_a[g], alu_b[g], alu_op[g], alu_cf[g]} != prev) begin
                prev <= {alu_a[g], alu_b[g], alu_op[g], alu_cf[g]};
                age  <= 0;
            end else if (age < 20) begin
                age <= age + 1;
            end
        end

        // Transaction model: ph counts edges since the grant, 0 means free to arbitrate.
        int           ph    = 0;
        logic         mlast = 1'b1;
        logic [1:0]   mg    = 2'b00;
        logic [W-1:0] ma    = '0;
        logic [W-1:0] mb    = '0;
        logic [7:0]   mop   = 8'h00;
        logic         mcf   = 1'b0;
        logic [34:0]  mres  = '0;
        logic         w_s;

        assign w_s = (req[g] == 2'b11) ? ~mlast : req[g][1];

        always @(posedge clk or negedge rn) begin
            if (!rn) begin
                ph <= 0; mlast <= 1'b1; mg <= 2'b00; ma <= '0; mb <= '0;
                mop <= 8'h00; mcf <= 1'b0; mres <= '0;
            end else if (ph == 0) begin
                if (req[g] != 2'b00) begin
                    mg    <= w_s ? 2'b10 : 2'b01;
                    mlast <= w_s;
                    ma    <= w_s ? a1[g] : a0[g];
                    mb    <= w_s ? b1[g] : b0[g];
                    mop   <= w_s ? op1[g] : op0[g];
                    mcf   <= cin[g][w_s];
                    ph    <= 1;
                end
            end else if (ph == L + 1) begin
                ph <= 0;
            end else begin
                if (ph == L) mres <= alu_f(mop, ma, mb, mcf);
                ph <= ph + 1;
            end
        end

        logic [80:0] act_v;
        logic [80:0] exp_v;
        assign act_v = {gnt[g], done[g], busy[g], res[g], res_c[g], res_cf[g], res_zf[g], res_of[g],
                        alu_a[g], alu_b[g], alu_op[g], alu_cf[g]};
        assign exp_v = {(ph != 0) ? mg : 2'b00, (ph == L + 1) ? mg : 2'b00, ph != 0, mres,
                        ma, mb, mop, mcf};

        always @(negedge clk) begin
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_lat%0d t=%0t: got %h expected %h", L, $time, act_v, exp_v);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic set0(input int d, input logic [7:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic c);
        op0[d] = op; a0[d] = a; b0[d] = b; cin[d][0] = c;
    endtask

    task automatic set1(input int d, input logic [7:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic c);
        op1[d] = op; a1[d] = a; b1[d] = b; cin[d][1] = c;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req[d] = 2'b00; cin[d] = 2'b00;
            set0(d, 8'h00, 16'h0000, 16'h0000, 1'b0);
            set1(d, 8'h00, 16'h0000, 16'h0000, 1'b0);
        end
        tick(3);
        chk("rst_gnt", 32'(gnt[0]), 32'h0);
        chk("rst_busy", 32'(busy[1]), 32'h0);
        chk("rst_res", 32'(res[0]), 32'h0);

        // Tie straight out of reset on LAT=1: port 0 first, then strict alternation.
        set0(0, 8'h01, 16'h0001, 16'h0001, 1'b0);
        set1(0, 8'h03, 16'h0005, 16'h0005, 1'b0);
        req[0] = 2'b11;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        tick(1); chk("tie_gnt0", 32'(gnt[0]), 32'h1);
        tick(1); chk("tie_done0", 32'(done[0]), 32'h1); chk("tie_res0", 32'(res[0]), 32'h2);
        tick(3); chk("tie_done1", 32'(done[0]), 32'h2); chk("tie_res1", 32'(res[0]), 32'h0);
        chk("tie_zf1", 32'(res_zf[0]), 32'h1);
        tick(3); chk("tie_done2", 32'(done[0]), 32'h1);
        req[0] = 2'b00;
        tick(3);

        // Single op on LAT=1.
        set0(0, 8'h01, 16'h0003, 16'h0004, 1'b0);
        req[0] = 2'b01;
        tick(1); chk("t1_gnt", 32'(gnt[0]), 32'h1); chk("t1_done_early", 32'(done[0]), 32'h0);
        tick(1); chk("t1_done", 32'(done[0]), 32'h1); chk("t1_res", 32'(res[0]), 32'h7);
        chk("t1_zf", 32'(res_zf[0]), 32'h0);
        req[0] = 2'b00;
        tick(1); chk("t1_done_off", 32'(done[0]), 32'h0); chk("t1_busy_off", 32'(busy[0]), 32'h0);

        // Carry/overflow capture, then hold.
        set0(0, 8'h01, 16'hFFFF, 16'h0001, 1'b0);
        req[0] = 2'b01;
        tick(2); chk("cy_res", 32'(res[0]), 32'h0); chk("cy_cf", 32'(res_cf[0]), 32'h1);
        chk("cy_zf", 32'(res_zf[0]), 32'h1);
        req[0] = 2'b00;
        tick(3); chk("cy_hold_res", 32'(res[0]), 32'h0); chk("cy_hold_cf", 32'(res_cf[0]), 32'h1);

        // Carry-in from port 1 reaches the ALU.
        set1(0, 8'h01, 16'h0002, 16'h0003, 1'b1);
        req[0] = 2'b10;
        tick(2); chk("cin_res", 32'(res[0]), 32'h6);
        req[0] = 2'b00;
        tick(2);

        // LAT=3: done three edges after the grant while port 1 operands churn.
        set0(1, 8'h01, 16'h1234, 16'h1111, 1'b0);
        req[1] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            set1(1, 8'h03 ^ 8'(i), 16'hAAAA + 16'(i), 16'h5555 - 16'(i), i[0]);
            chk("l3_no_done", 32'(done[1]), 32'h0);
            chk("l3_alu_a", 32'(alu_a[1]), 32'h1234);
        end
        tick(1); chk("l3_done", 32'(done[1]), 32'h1); chk("l3_res", 32'(res[1]), 32'h2345);
        req[1] = 2'b00;
        tick(2);

        // Withdraw: port 1 drops req mid-WAIT, port 0 queues behind it.
        set1(1, 8'h03, 16'h0010, 16'h0003, 1'b0);
        req[1] = 2'b10;
        tick(1); chk("wd_gnt1", 32'(gnt[1]), 32'h2);
        set0(1, 8'h01, 16'h0020, 16'h0002, 1'b0);
        req[1] = 2'b01;
        tick(3); chk("wd_done1", 32'(done[1]), 32'h2); chk("wd_res1", 32'(res[1]), 32'h000D);
        tick(1); chk("wd_gap", 32'(gnt[1]), 32'h0);
        tick(1); chk("wd_gnt0", 32'(gnt[1]), 32'h1);
        tick(3); chk("wd_done0", 32'(done[1]), 32'h1); chk("wd_res0", 32'(res[1]), 32'h0022);
        req[1] = 2'b00;
        tick(2);

        // Reset one cycle into WAIT; afterwards a tie must go to port 0 again.
        set0(1, 8'h01, 16'h0100, 16'h0001, 1'b0);
        req[1] = 2'b01;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n[1] = 1'b0;
        #1;
        chk("mr_gnt", 32'(gnt[1]), 32'h0); chk("mr_busy", 32'(busy[1]), 32'h0);
        chk("mr_alu_a", 32'(alu_a[1]), 32'h0); chk("mr_res", 32'(res[1]), 32'h0);
        tick(4); chk("mr_no_done", 32'(done[1]), 32'h0);
        set1(1, 8'h03, 16'h0009, 16'h0002, 1'b0);
        req[1] = 2'b11;
        rst_n[1] = 1'b1;
        tick(1); chk("mr_gnt0", 32'(gnt[1]), 32'h1);
        tick(3); chk("mr_done0", 32'(done[1]), 32'h1); chk("mr_res0", 32'(res[1]), 32'h0101);
        tick(5); chk("mr_done1", 32'(done[1]), 32'h2); chk("mr_res1", 32'(res[1]), 32'h0007);
        req[1] = 2'b00;
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit `alu` instance between two requesters: port 0 is the CPU execute FSM, port 1 is the address/stack-pointer unit. The block registers a request's operands and opcode onto the ALU inputs and waits a fixed latency. It then captures the ALU outputs and flags and returns them to the winning requester with a one-cycle done pulse. Ties are resolved round-robin, so neither requester can starve the other.

## Interface
Parameters:
- `LAT`, 1: ALU result latency in clocks, counted from the edge that drives `alu_a/alu_b/alu_op`. Legal range 1..15.
- `W`, 16: datapath width.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in 2: per-requester request. Held high, with operands stable, until that requester's `done` bit pulses.
- `op0`, `op1` in 8: ALU opcode from each requester, using the xADD..xTEST encoding (e.g. xADD = 8'h01, xSUB = 8'h03).
- `a0`, `b0`, `a1`, `b1` in W: operands.
- `cin` in 2: per-requester carry-in.
- `gnt` out 2: one-hot; marks the requester owning the ALU.
- `done` out 2: one-cycle pulse to the served requester.
- `busy` out 1: high in any state other than IDLE.
- `res`, `res_c` out W: captured `acc` and `c` outputs.
- `res_cf`, `res_zf`, `res_of` out 1: captured flags.
- `alu_a`, `alu_b` out W; `alu_op` out 8; `alu_cf` out 1: drive the ALU inputs.
- `alu_acc`, `alu_c` in W; `alu_cflag`, `alu_zflag`, `alu_oflag` in 1: ALU outputs.

## Operation
Reset (asynchronous, while `rst_n` = 0):
- State IDLE, all outputs 0, `cnt` = 0.
- Round-robin pointer `last` = 1, so requester 0 wins the first tie.
- Any operation in flight is abandoned and no `done` is issued.

States:
- IDLE:
  - If `req` = 00, stay in IDLE.
  - If exactly one `req` bit is set, grant that requester.
  - If both are set, grant requester `~last`.
  - On a grant, at the same edge: set `gnt`, load `alu_a/alu_b/alu_op/alu_cf` from the winner, set `last` = winner, set `cnt` = LAT, go to WAIT.
- WAIT:
  - Decrement `cnt` each edge.
  - On the edge where `cnt` = 1, capture `alu_acc/alu_c/flags` into the `res*` outputs, raise `done[winner]`, go to DONE.
- DONE:
  - `done` deasserts, `gnt` clears, all `req` inputs are ignored.
  - Next state is IDLE unconditionally. This cycle lets the requester drop `req` before the next arbitration.

Datapath and output rules:
- `alu_*` outputs hold their values through WAIT and DONE. They change only on a grant.
- `res*` outputs hold their values until the next capture.
- The arbiter does not interpret opcodes. It passes all W bits and `c` through unchanged, with no width conversion.

Boundary conditions:
- Requester drops `req` during WAIT: the operation completes, `done` still pulses, and the result is valid. Discarding it is the requester's responsibility.
- New request arrives during WAIT or DONE: it waits and is arbitrated in the next IDLE.
- Both requesters hold `req` continuously: grants strictly alternate 0,1,0,1.
- `req` rises in the DONE cycle for the just-served port: it is ignored until IDLE and then competes normally. `last` gives the other port priority.
- `rst_n` deasserts: the first grant is possible on the first rising edge after deassertion.

## Timing
- Grant edge E0: `gnt`, `busy` and `alu_*` valid after E0.
- Capture edge E0+LAT: `res*` valid and `done` high for exactly one cycle.
- E0+LAT+1: back in IDLE with `busy` = 0. The earliest next grant is edge E0+LAT+2.
- Request-to-done latency is LAT+1 edges when `req` is already high before E0. Throughput is one operation per LAT+2 cycles.
- `gnt` and `done` are registered with no combinational path from `req`. The `alu_*` outputs are registered.

## Test plan
- Single op, LAT=1: `req`=01, op0=8'h01, a0=16'h0003, b0=16'h0004 → `gnt`=01 after E0; `done`=01 for one cycle after E1; `res`=16'h0007, `res_zf`=0.
- Tie after reset: `req`=11 held continuously with distinct ops (port 0 ADD 1+1, port 1 SUB 5-5) → serves port 0, then port 1, alternating. The port 1 result has `res`=0 and `res_zf`=1. A `done` pulse occurs every 3 cycles.
- Carry/overflow capture: op 8'h01, a=16'hFFFF, b=16'h0001 → `res`=16'h0000, `res_cf`=1, `res_zf`=1. Values hold until the next capture.
- LAT=3: single request → `done` exactly 3 edges after the grant edge. `alu_*` stay stable through WAIT even when port 1 toggles its operands.
- Reset mid-WAIT: assert `rst_n`=0 one cycle after the grant → all outputs 0 immediately, no `done`. After release, `req`=11 grants port 0 first.
- Withdraw: port 1 drops `req` one cycle after its grant → `done`=10 still pulses. A port 0 request pending meanwhile is granted at the edge right after DONE.
